fdivsqrt_otfc_ctrl: RTL



---
 rtl/fdivsqrt_otfc_pkg.sv | 31 +++
 rtl/fdivsqrt_otfc_step.sv | 38 +++
 rtl/fdivsqrt_otfc_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fdivsqrt_otfc_pkg.sv
// Shared types and init constants for the radix-2 OTFC sequencer.
// Optional feature macro: FDIVSQRT_EARLY_TERM_EN (used by fdivsqrt_otfc_ctrl).
package fdivsqrt_otfc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic up;
      logic un;
   } digit_t;

   localparam int MAX_W = 64;

   // Returned wide; callers size-cast to their DIVB-dependent width.
   function automatic logic [MAX_W-1:0] c_init(input int divb);
      return 64'd3 << divb;
   endfunction

   function automatic logic [MAX_W-1:0] u_div_init(input int divb);
      return (divb >= 0) ? 64'd0 : 64'd0;
   endfunction

   function automatic logic [MAX_W-1:0] u_sqrt_init(input int divb);
      return 64'd1 << divb;
   endfunction

endpackage

// File: rtl/fdivsqrt_otfc_step.sv
// One combinational OTFC step: shifts the C thermometer, derives the digit
// position mask K and produces the next U/UM. up&un together acts as digit 0.
module fdivsqrt_otfc_step
   import fdivsqrt_otfc_pkg::*;
#(
   parameter int DIVB = 24
) (
   input  logic [DIVB+1:0] c,
   input  logic [DIVB:0]   u,
   input  logic [DIVB:0]   um,
   input  digit_t          dig,
   output logic [DIVB+1:0] cn,
   output logic [DIVB:0]   u_nxt,
   output logic [DIVB:0]   um_nxt
);

   logic [DIVB:0] k;

   always_comb begin
      cn     = {1'b1, c[DIVB+1:1]};
      k      = cn[DIVB:0] & ~(cn[DIVB:0] << 1);
      u_nxt  = u;
      um_nxt = um;
      case ({dig.up, dig.un})
         2'b10: begin
            u_nxt  = u | k;
            um_nxt = u;
         end
         2'b01: begin
            u_nxt  = um | k;
         end
         default: begin
            um_nxt = um | k;
         end
      endcase
   end

endmodule

// File: rtl/fdivsqrt_otfc_ctrl.sv
// Radix-2 OTFC sequencer: start handshake, per-digit U/UM update, result handshake.
// Optional macro FDIVSQRT_EARLY_TERM_EN adds rem_zero/out_early early termination.
module fdivsqrt_otfc_ctrl
   import fdivsqrt_otfc_pkg::*;
#(
   parameter int DIVB  = 24,
   parameter int ITERW = $clog2(DIVB+2)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sqrt,
   input  logic [ITERW-1:0] in_iters,
   output logic             step_en,
   input  logic             dig_valid,
   input  logic             dig_up,
   input  logic             dig_un,
`ifdef FDIVSQRT_EARLY_TERM_EN
   input  logic             rem_zero,
   output logic             out_early,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DIVB:0]    out_u,
   output logic [DIVB:0]    out_um,
   output logic             out_err
);

   localparam logic [DIVB+1:0]  C_INIT    = (DIVB+2)'(c_init(DIVB));
   localparam logic [DIVB:0]    U_DIV     = (DIVB+1)'(u_div_init(DIVB));
   localparam logic [DIVB:0]    U_SQRT    = (DIVB+1)'(u_sqrt_init(DIVB));
   localparam logic [ITERW-1:0] MAX_ITERS = ITERW'(DIVB+1);

   state_t           state_q, state_d;
   logic [DIVB+1:0]  c_q, c_d, c_step;
   logic [DIVB:0]    u_q, u_d, u_step;
   logic [DIVB:0]    um_q, um_d, um_step;
   logic [ITERW-1:0] cnt_q, cnt_d, iters_clamped;
   logic             err_q, err_d;
`ifdef FDIVSQRT_EARLY_TERM_EN
   logic             early_q, early_d;
`endif
   digit_t           dig;

   assign dig = '{up: dig_up, un: dig_un};

   fdivsqrt_otfc_step #(.DIVB(DIVB)) u_step_inst (
      .c      (c_q),
      .u      (u_q),
      .um     (um_q),
      .dig    (dig),
      .cn     (c_step),
      .u_nxt  (u_step),
      .um_nxt (um_step)
   );

   always_comb begin
      state_d       = state_q;
      c_d           = c_q;
      u_d           = u_q;
      um_d          = um_q;
      cnt_d         = cnt_q;
      err_d         = err_q;
`ifdef FDIVSQRT_EARLY_TERM_EN
      early_d       = early_q;
`endif
      iters_clamped = (in_iters > MAX_ITERS) ? MAX_ITERS : in_iters;

      // flush wins over every handshake and leaves the datapath registers untouched
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  c_d     = C_INIT;
                  u_d     = in_sqrt ? U_SQRT : U_DIV;
                  um_d    = '0;
                  cnt_d   = iters_clamped;
                  err_d   = 1'b0;
`ifdef FDIVSQRT_EARLY_TERM_EN
                  early_d = 1'b0;
`endif
                  state_d = (iters_clamped == '0) ? ST_DONE : ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (dig_valid) begin
                  c_d   = c_step;
                  u_d   = u_step;
                  um_d  = um_step;
                  cnt_d = cnt_q - ITERW'(1);
                  if (dig_up && dig_un) begin
                     err_d = 1'b1;
                  end
                  if (cnt_q == ITERW'(1)) begin
                     state_d = ST_DONE;
                  end
`ifdef FDIVSQRT_EARLY_TERM_EN
                  if (rem_zero) begin
                     state_d = ST_DONE;
                     early_d = 1'b1;
                  end
`endif
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         c_q     <= '0;
         u_q     <= '0;
         um_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
`ifdef FDIVSQRT_EARLY_TERM_EN
         early_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         u_q     <= u_d;
         um_q    <= um_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`ifdef FDIVSQRT_EARLY_TERM_EN
         early_q <= early_d;
`endif
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign step_en   = (state_q == ST_BUSY);
   assign out_valid = (state_q == ST_DONE);
   assign out_u     = u_q;
   assign out_um    = um_q;
   assign out_err   = err_q;
`ifdef FDIVSQRT_EARLY_TERM_EN
   assign out_early = early_q;
`endif

endmodule
